// File: rtl/regfile_pkg.sv
// Shared types for the CPU register file.
// Build option: CPU_REGFILE_BYPASS_EN selects write-through on same-cycle capture.
package regfile_pkg;

    typedef enum logic [1:0] {
        RD_HOLD    = 2'd0,
        RD_CAPTURE = 2'd1,
        RD_REFRESH = 2'd2
    } rd_action_e;

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: address latch, output register, stall refresh and capture mux.
// Build option: CPU_REGFILE_BYPASS_EN returns the coincident write data on capture.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int REG_WIDTH   = 32,
    parameter int REGNO_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic [REGNO_WIDTH-1:0] rd_no,
    input  logic [REG_WIDTH-1:0]   rd_val,
    input  logic [REGNO_WIDTH-1:0] addr,
    input  logic [REG_WIDTH-1:0]   rdata,
    output logic [REG_WIDTH-1:0]   val
);

    logic [REGNO_WIDTH-1:0] addr_q;
    logic [REG_WIDTH-1:0]   val_nxt;
    logic [REG_WIDTH-1:0]   capture_val;
    rd_action_e             action;

    always_comb begin
        capture_val = rdata;
`ifdef CPU_REGFILE_BYPASS_EN
        if (rd_no != '0 && rd_no == addr) begin
            capture_val = rd_val;
        end
`endif
    end

    always_comb begin
        action = RD_HOLD;
        if (!stall) begin
            action = RD_CAPTURE;
        end else if (rd_no != '0 && rd_no == addr_q) begin
            action = RD_REFRESH;
        end
    end

    always_comb begin
        val_nxt = val;
        unique case (action)
            RD_CAPTURE: val_nxt = capture_val;
            RD_REFRESH: val_nxt = rd_val;
            RD_HOLD:    val_nxt = val;
            default:    val_nxt = val;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            val    <= '0;
        end else begin
            if (!stall) begin
                addr_q <= addr;
            end
            val <= val_nxt;
        end
    end

endmodule

// File: rtl/regfile.sv
// CPU general-purpose register file: r0 hard-wired to zero, two registered read ports.
// Build option: CPU_REGFILE_BYPASS_EN (see regfile_rdport).
module regfile
    import regfile_pkg::*;
#(
    parameter int REG_WIDTH   = 32,
    parameter int REGNO_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_stall,
    input  logic [REGNO_WIDTH-1:0] i_rd_no,
    input  logic [REG_WIDTH-1:0]   i_rd_val,
    input  logic [REGNO_WIDTH-1:0] i_rs_no,
    input  logic [REGNO_WIDTH-1:0] i_rt_no,
    output logic [REG_WIDTH-1:0]   o_rs_val,
    output logic [REG_WIDTH-1:0]   o_rt_val
);

    localparam int DEPTH = 1 << REGNO_WIDTH;

    logic [REG_WIDTH-1:0] mem [DEPTH];
    logic [REG_WIDTH-1:0] rs_data;
    logic [REG_WIDTH-1:0] rt_data;

    // Entry 0 is never written; the explicit zero keeps it clean even before first reset.
    assign rs_data = (i_rs_no == '0) ? '0 : mem[i_rs_no];
    assign rt_data = (i_rt_no == '0) ? '0 : mem[i_rt_no];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_rd_no != '0) begin
            mem[i_rd_no] <= i_rd_val;
        end
    end

    regfile_rdport #(
        .REG_WIDTH   (REG_WIDTH),
        .REGNO_WIDTH (REGNO_WIDTH)
    ) u_rdport_rs (
        .clk    (clk),
        .rst    (rst),
        .stall  (i_stall),
        .rd_no  (i_rd_no),
        .rd_val (i_rd_val),
        .addr   (i_rs_no),
        .rdata  (rs_data),
        .val    (o_rs_val)
    );

    regfile_rdport #(
        .REG_WIDTH   (REG_WIDTH),
        .REGNO_WIDTH (REGNO_WIDTH)
    ) u_rdport_rt (
        .clk    (clk),
        .rst    (rst),
        .stall  (i_stall),
        .rd_no  (i_rd_no),
        .rd_val (i_rd_val),
        .addr   (i_rt_no),
        .rdata  (rt_data),
        .val    (o_rt_val)
    );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed steps followed by random traffic against a reference model.
module tb_regfile;

`ifdef CPU_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_stall = 1'b0;
    logic [4:0]  i_rd_no = '0;
    logic [31:0] i_rd_val = '0;
    logic [4:0]  i_rs_no = '0;
    logic [4:0]  i_rt_no = '0;
    logic [31:0] o_rs_val;
    logic [31:0] o_rt_val;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural registers plus what each port should present.
    logic [31:0] model [32];
    logic [4:0]  m_rsq = '0;
    logic [4:0]  m_rtq = '0;
    logic [31:0] exp_rs = '0;
    logic [31:0] exp_rt = '0;

    regfile dut (
        .clk      (clk),
        .rst      (rst),
        .i_stall  (i_stall),
        .i_rd_no  (i_rd_no),
        .i_rd_val (i_rd_val),
        .i_rs_no  (i_rs_no),
        .i_rt_no  (i_rt_no),
        .o_rs_val (o_rs_val),
        .o_rt_val (o_rt_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] read_now(input logic [4:0] idx, input logic [4:0] wr,
                                             input logic [31:0] wv);
        if (idx == 5'd0) return 32'h0;
        if (BYP && wr != 5'd0 && wr == idx) return wv;
        return model[idx];
    endfunction

    task automatic cycle(input string tag, input logic r, input logic s, input logic [4:0] rd,
                         input logic [31:0] v, input logic [4:0] a, input logic [4:0] b);
        rst = r; i_stall = s; i_rd_no = rd; i_rd_val = v; i_rs_no = a; i_rt_no = b;
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            m_rsq = '0; m_rtq = '0; exp_rs = '0; exp_rt = '0;
        end else begin
            if (!s) begin
                m_rsq = a; m_rtq = b;
                exp_rs = read_now(a, rd, v);
                exp_rt = read_now(b, rd, v);
            end else begin
                if (rd != 5'd0 && rd == m_rsq) exp_rs = v;
                if (rd != 5'd0 && rd == m_rtq) exp_rt = v;
            end
            if (rd != 5'd0) model[rd] = v;
        end
        @(posedge clk);
        #1;
        check({tag, ".rs"}, o_rs_val, exp_rs);
        check({tag, ".rt"}, o_rt_val, exp_rt);
    endtask

    initial begin
        logic [4:0]  rd, a, b;
        logic [31:0] v;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        cycle("reset0", 1, 0, 5'd0, 32'h0, 5'd3, 5'd4);
        cycle("reset1", 1, 0, 5'd7, 32'h12345678, 5'd7, 5'd7);
        for (int i = 0; i < 32; i++) begin
            cycle("rst_read", 0, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
        end

        cycle("wr_r5", 0, 0, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        cycle("rd_r5", 0, 0, 5'd0, 32'h0, 5'd5, 5'd0);
        check("rd_r5_lit", o_rs_val, 32'hDEADBEEF);

        cycle("wr_r0", 0, 0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        cycle("rd_r0", 0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        check("rd_r0_lit", o_rs_val, 32'h0);

        cycle("pre_r7", 0, 0, 5'd7, 32'h11111111, 5'd0, 5'd0);
        cycle("coll_r7", 0, 0, 5'd7, 32'h22222222, 5'd7, 5'd0);
        check("coll_r7_lit", o_rs_val, BYP ? 32'h22222222 : 32'h11111111);
        cycle("after_r7", 0, 0, 5'd0, 32'h0, 5'd7, 5'd7);
        check("after_r7_lit", o_rt_val, 32'h22222222);

        cycle("pre_r9", 0, 0, 5'd9, 32'h1, 5'd0, 5'd0);
        cycle("cap_r9", 0, 0, 5'd0, 32'h0, 5'd0, 5'd9);
        check("cap_r9_lit", o_rt_val, 32'h1);
        cycle("stall_wr9", 0, 1, 5'd9, 32'hABCD, 5'd0, 5'd3);
        check("stall_wr9_lit", o_rt_val, 32'hABCD);
        cycle("stall_wr3", 0, 1, 5'd3, 32'h3333, 5'd1, 5'd3);
        check("stall_wr3_lit", o_rt_val, 32'hABCD);
        cycle("stall_idle", 0, 1, 5'd0, 32'h0, 5'd2, 5'd3);
        cycle("unstall", 0, 0, 5'd0, 32'h0, 5'd9, 5'd3);
        check("unstall_lit", o_rt_val, 32'h3333);

        cycle("stall_pre", 0, 1, 5'd4, 32'h4444, 5'd4, 5'd9);
        cycle("rst_stall", 1, 1, 5'd4, 32'h4444, 5'd4, 5'd9);
        cycle("post_rst", 0, 0, 5'd0, 32'h0, 5'd4, 5'd9);
        check("post_rst_lit", o_rs_val, 32'h0);

        for (int n = 0; n < 600; n++) begin
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
            a  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            b  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            v  = $urandom;
            cycle("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), rd, v, a, b);
        end

        for (int i = 0; i < 32; i++) begin
            cycle("final_read", 0, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the CPU core: it accepts the register-write stream produced by the writeback stage and serves the two source operands to decode/execute. Register 0 is hard-wired to zero, and a write to register 0 is the "no write" encoding used by nullified instructions. Reads are registered with one-cycle latency. While the core is stalled, each read port holds its operand but refreshes it if the register it is presenting is overwritten.

## Interface

Parameters:
- REG_WIDTH, 32, data width of each register (matches `CPU_REG_WIDTH`).
- REGNO_WIDTH, 5, register index width (matches `CPU_REGNO_WIDTH`); depth is 2**REGNO_WIDTH.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- i_stall  input  1  core stall (OR of fetch/exec/mem stalls); freezes read ports.
- i_rd_no  input  REGNO_WIDTH  write index from writeback; 0 = no write.
- i_rd_val  input  REG_WIDTH  write data from writeback.
- i_rs_no  input  REGNO_WIDTH  read port A index.
- i_rt_no  input  REGNO_WIDTH  read port B index.
- o_rs_val  output  REG_WIDTH  read port A data, registered.
- o_rt_val  output  REG_WIDTH  read port B data, registered.

## Operation

- Storage: 2**REGNO_WIDTH entries. Entry 0 is never written and always reads 0.
- Write:
  - When rst=0 and i_rd_no≠0, reg[i_rd_no] is updated with i_rd_val at the edge.
  - Writes are independent of i_stall. Writeback holds its outputs during a stall, so repeated identical writes are benign.
- Read capture (i_stall=0):
  - Latch i_rs_no and i_rt_no into internal address registers rs_q and rt_q.
  - Load o_rs_val with reg[i_rs_no] and o_rt_val with reg[i_rt_no] (bypass per Configuration).
- Read hold (i_stall=1):
  - i_rs_no and i_rt_no are ignored; rs_q and rt_q are unchanged.
  - If i_rd_no≠0 and i_rd_no==rs_q, o_rs_val is loaded with i_rd_val. Otherwise it holds.
  - Port B behaves the same way against rt_q.
  - This refresh is unconditional; it does not depend on the configuration macro.
- Index 0 on a read port always yields 0. A write with i_rd_no=0 never matches.
- Both read ports may name the same register, and both may match a write in the same cycle.
- Reset (rst=1 at an edge):
  - All entries are cleared to 0.
  - rs_q, rt_q, o_rs_val and o_rt_val are cleared to 0.
  - Any write presented that cycle is discarded.
  - Reset in the middle of a stall also clears everything.

## Timing

- Read latency: index presented in cycle N, data valid on o_*_val after edge N+1.
- Write-to-read:
  - A write at edge N is visible to any read captured at edge N+1 or later.
  - A read captured at the same edge N follows the Configuration rules.
- Stall refresh: a matching write at edge N updates the held output after edge N.
- Reset values: o_rs_val=0, o_rt_val=0, every entry=0.
- No handshake signals; the block is always ready.

## Configuration

- `CPU_REGFILE_BYPASS_EN` defined:
  - A capture that coincides with a write to the same non-zero index returns i_rd_val.
  - This is write-through: the new value is seen in the same cycle.
- Undefined:
  - The same capture returns the old stored value (read-before-write).
  - The pipeline must then cover that hazard by forwarding or stalling.
- The stall-hold refresh is present in both builds.

## Structure

- The width macros `CPU_REG_WIDTH` and `CPU_REGNO_WIDTH` stay in the shared cpu_common header.
- No new package constants are required.
- One sub-module is natural: `regfile_rdport`. It holds the address latch, the output register, the hold/refresh logic and the bypass mux, and is instantiated twice.
- The storage array and write logic live in the top module.

## Test plan

- Reset:
  - Stimulus: assert rst for 2 cycles, then read indices 0..31.
  - Required response: all reads return 0x00000000; outputs are 0 during reset.
- Basic write/read:
  - Stimulus: write r5=0xDEADBEEF; next cycle read rs=5, rt=0.
  - Required response: one cycle later o_rs_val=0xDEADBEEF and o_rt_val=0.
- r0 immutability:
  - Stimulus: write i_rd_no=0, i_rd_val=0xFFFFFFFF; then read rs=0.
  - Required response: 0.
- Same-cycle collision, r7 preloaded with 0x11111111:
  - Stimulus: write r7=0x22222222 while capturing rs=7.
  - Required response with `CPU_REGFILE_BYPASS_EN`: o_rs_val=0x22222222.
  - Required response without it: o_rs_val=0x11111111, then 0x22222222 on the following capture.
- Stall refresh:
  - Stimulus: capture rt=9 (value 0x1); raise i_stall; write r9=0xABCD; change i_rt_no to 3.
  - Required response: o_rt_val becomes 0xABCD and stays there until i_stall falls, after which it shows r3.
- Reset during stall:
  - Stimulus: with i_stall=1 and an outstanding write, assert rst.
  - Required response: outputs and all entries read 0; the write is not stored.
